// File: rtl/adder_arbiter.sv
// adder_arbiter: arbitrates two requesters onto one shared multi-cycle adder.
// Ties alternate between requesters; each result is held until the consumer takes it.
module adder_arbiter #(
    parameter int unsigned N   = 32,
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_cin,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_sum
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_id;
    logic [N-1:0]     r_add_a;
    logic [N-1:0]     r_add_b;
    logic             r_add_cin;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [N-1:0]     r_resp_sum;

    logic             w_any_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic [N-1:0]     w_sel_a;
    logic [N-1:0]     w_sel_b;
    logic             w_sel_cin;

    // On a tie the requester that did not win last time is granted.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = (r_state == IDLE) & w_any_valid & ~rst;

    assign req0_ready  = w_accept & ~w_grant_id;
    assign req1_ready  = w_accept &  w_grant_id;

    assign w_sel_a     = w_grant_id ? req1_a   : req0_a;
    assign w_sel_b     = w_grant_id ? req1_b   : req0_b;
    assign w_sel_cin   = w_grant_id ? req1_cin : req0_cin;

    assign add_a       = r_add_a;
    assign add_b       = r_add_b;
    assign add_cin     = r_add_cin;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_sum    = r_resp_sum;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_add_cin    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_add_a      <= w_sel_a;
                        r_add_b      <= w_sel_b;
                        r_add_cin    <= w_sel_cin;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_cnt        <= CNT_W'(LAT - 1);
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_sum   <= add_sum;
                        r_resp_id    <= r_id;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model; LAT=1/2/4 instances share stimulus.
module tb_adder_arbiter;

    localparam int unsigned N     = 32;
    localparam int          LAT_M = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         v0, v1, c0, c1, rr;
    logic [N-1:0] a0, b0, a1, b1;

    logic         rdy0_2, rdy1_2, addc_2, rv_2, rid_2;
    logic [N-1:0] adda_2, addb_2, sum_2, rsum_2;
    logic         rdy0_1, rdy1_1, addc_1, rv_1, rid_1;
    logic [N-1:0] adda_1, addb_1, sum_1, rsum_1;
    logic         rdy0_4, rdy1_4, addc_4, rv_4, rid_4;
    logic [N-1:0] adda_4, addb_4, sum_4, rsum_4;

    // Shared adders seen by each instance.
    assign sum_2 = adda_2 + addb_2 + {{(N-1){1'b0}}, addc_2};
    assign sum_1 = adda_1 + addb_1 + {{(N-1){1'b0}}, addc_1};
    assign sum_4 = adda_4 + addb_4 + {{(N-1){1'b0}}, addc_4};

    adder_arbiter #(.N(N), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0_2), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(rdy1_2), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .add_a(adda_2), .add_b(addb_2), .add_cin(addc_2), .add_sum(sum_2),
        .resp_valid(rv_2), .resp_ready(rr), .resp_id(rid_2), .resp_sum(rsum_2)
    );

    adder_arbiter #(.N(N), .LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0_1), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(rdy1_1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .add_a(adda_1), .add_b(addb_1), .add_cin(addc_1), .add_sum(sum_1),
        .resp_valid(rv_1), .resp_ready(rr), .resp_id(rid_1), .resp_sum(rsum_1)
    );

    adder_arbiter #(.N(N), .LAT(4)) dut_lat4 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0_4), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(rdy1_4), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .add_a(adda_4), .add_b(addb_4), .add_cin(addc_4), .add_sum(sum_4),
        .resp_valid(rv_4), .resp_ready(rr), .resp_id(rid_4), .resp_sum(rsum_4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [N-1:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic c);
        logic [N:0] t;
        t = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        return t[N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_op(input logic k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic c, output logic [N-1:0] s, output logic id,
                          output int lat);
        int w;
        lat = -1; s = '0; id = 1'b0;
        rr = 1'b1;
        if (k == 1'b0) begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
        else           begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
        #1;
        w = 0;
        while (!(k ? rdy1_2 : rdy0_2) && w < 20) begin
            @(posedge clk); #2; w++;
        end
        if (w < 20) begin
            tick();
            v0 = 1'b0; v1 = 1'b0;
            for (int e = 1; e <= 40; e++) begin
                tick();
                if (rv_2) begin lat = e; s = rsum_2; id = rid_2; break; end
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rr = 1'b0;
        a0 = $urandom; b0 = $urandom; c0 = 1'b1; a1 = $urandom; b1 = $urandom; c1 = 1'b1;
        tick(); tick();
        n_checks++; if (rdy0_2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %0b want 0", rdy0_2); end
        n_checks++; if (rdy1_2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %0b want 0", rdy1_2); end
        n_checks++; if (rv_2 !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b want 0", rv_2); end
        n_checks++; if (rid_2 !== 1'b0) begin n_fail++; $display("FAIL reset_resp_id: got %0b want 0", rid_2); end
        n_checks++; if (rsum_2 !== '0) begin n_fail++; $display("FAIL reset_resp_sum: got %0h want 0", rsum_2); end
        n_checks++; if (adda_2 !== '0) begin n_fail++; $display("FAIL reset_add_a: got %0h want 0", adda_2); end
        n_checks++; if (addb_2 !== '0) begin n_fail++; $display("FAIL reset_add_b: got %0h want 0", addb_2); end
        n_checks++; if (addc_2 !== 1'b0) begin n_fail++; $display("FAIL reset_add_cin: got %0b want 0", addc_2); end
        v0 = 1'b0; v1 = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rr = 1'b1; v0 = 1'b1; a0 = 32'h0000_0005; b0 = 32'h0000_0003; c0 = 1'b1;
        #1;
        n_checks++; if (rdy0_2 !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %0b want 1", rdy0_2); end
        n_checks++; if (rdy1_2 !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %0b want 0", rdy1_2); end
        tick();
        v0 = 1'b0;
        n_checks++; if (adda_2 !== 32'h5 || addb_2 !== 32'h3 || addc_2 !== 1'b1) begin
            n_fail++; $display("FAIL single_operands: got %0h/%0h/%0b want 5/3/1", adda_2, addb_2, addc_2); end
        n_checks++; if (rv_2 !== 1'b0) begin n_fail++; $display("FAIL single_valid_e0: got %0b want 0", rv_2); end
        tick();
        n_checks++; if (rv_2 !== 1'b0) begin n_fail++; $display("FAIL single_valid_e1: got %0b want 0", rv_2); end
        tick();
        n_checks++; if (rv_2 !== 1'b1) begin n_fail++; $display("FAIL single_valid_e2: got %0b want 1", rv_2); end
        n_checks++; if (rsum_2 !== 32'h9) begin n_fail++; $display("FAIL single_sum: got %0h want 9", rsum_2); end
        n_checks++; if (rid_2 !== 1'b0) begin n_fail++; $display("FAIL single_id: got %0b want 0", rid_2); end
        tick();
        n_checks++; if (rv_2 !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %0b want 0", rv_2); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] q_sum[$];
        logic [N-1:0] exp_s;
        int  got;
        bit  both_bad;
        pulse_reset();
        rr = 1'b1; v0 = 1'b1; v1 = 1'b1;
        got = 0; both_bad = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
            a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
            #1;
            if (rdy0_2 && rdy1_2) both_bad = 1'b1;
            if (rdy0_2) q_sum.push_back(ref_add(a0, b0, c0));
            if (rdy1_2) q_sum.push_back(ref_add(a1, b1, c1));
            if (rv_2) begin
                exp_s = (q_sum.size() > 0) ? q_sum.pop_front() : '0;
                n_checks++; if (rid_2 !== 1'(got % 2)) begin n_fail++;
                    $display("FAIL fair_id[%0d]: got %0b want %0b", got, rid_2, 1'(got % 2)); end
                n_checks++; if (rsum_2 !== exp_s) begin n_fail++;
                    $display("FAIL fair_sum[%0d]: got %0h want %0h", got, rsum_2, exp_s); end
                got++;
            end
            tick();
        end
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL fair_count: got %0d want 4", got); end
        n_checks++; if (both_bad) begin n_fail++; $display("FAIL fair_exclusive: got both ready want one"); end
        v0 = 1'b0; v1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp0, exp1, hold_s;
        int  w;
        bit  r1_bad, hold_bad;
        rr = 1'b0;
        v0 = 1'b1; a0 = $urandom; b0 = $urandom; c0 = 1'b0;
        exp0 = ref_add(a0, b0, c0);
        #1;
        n_checks++; if (rdy0_2 !== 1'b1) begin n_fail++; $display("FAIL bp_accept0: got %0b want 1", rdy0_2); end
        tick();
        v0 = 1'b0; v1 = 1'b1; a1 = $urandom; b1 = $urandom; c1 = 1'b1;
        exp1 = ref_add(a1, b1, c1);
        r1_bad = 1'b0; hold_bad = 1'b0;
        w = 0;
        while (!rv_2 && w < 20) begin
            #1; if (rdy1_2 !== 1'b0) r1_bad = 1'b1;
            tick(); w++;
        end
        n_checks++; if (!rv_2) begin n_fail++; $display("FAIL bp_timeout: got valid 0 want 1"); end
        hold_s = rsum_2;
        n_checks++; if (hold_s !== exp0) begin n_fail++; $display("FAIL bp_sum0: got %0h want %0h", hold_s, exp0); end
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rv_2 !== 1'b1 || rsum_2 !== exp0 || rid_2 !== 1'b0) hold_bad = 1'b1;
            if (rdy1_2 !== 1'b0) r1_bad = 1'b1;
            tick();
        end
        n_checks++; if (hold_bad) begin n_fail++; $display("FAIL bp_hold: got unstable response want %0h id 0", exp0); end
        n_checks++; if (r1_bad) begin n_fail++; $display("FAIL bp_ready1_busy: got 1 want 0"); end
        rr = 1'b1;
        tick();
        #1;
        n_checks++; if (rdy1_2 !== 1'b1) begin n_fail++; $display("FAIL bp_ready1_idle: got %0b want 1", rdy1_2); end
        tick();
        v1 = 1'b0;
        w = 0;
        while (!rv_2 && w < 20) begin tick(); w++; end
        n_checks++; if (rid_2 !== 1'b1 || rsum_2 !== exp1) begin n_fail++;
            $display("FAIL bp_second: got id %0b sum %0h want id 1 sum %0h", rid_2, rsum_2, exp1); end
        tick();
    endtask

    task automatic test_wrap();
        logic [N-1:0] s;
        logic         id;
        int           lat;
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, id, lat);
        n_checks++; if (s !== 32'h0 || lat != LAT_M) begin n_fail++;
            $display("FAIL wrap_carry_out: got %0h lat %0d want 0 lat %0d", s, lat, LAT_M); end
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, s, id, lat);
        n_checks++; if (s !== 32'hFFFF_FFFF || id !== 1'b1) begin n_fail++;
            $display("FAIL wrap_all_ones: got %0h id %0b want ffffffff id 1", s, id); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        rr = 1'b1; v0 = 1'b1; a0 = $urandom; b0 = $urandom; c0 = 1'b1;
        #1;
        n_checks++; if (rdy0_2 !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got %0b want 1", rdy0_2); end
        tick();
        v0 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rv_2) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rmid_no_resp: got valid 1 want 0"); end
        v0 = 1'b1; v1 = 1'b1;
        #1;
        n_checks++; if (rdy0_2 !== 1'b1 || rdy1_2 !== 1'b0) begin n_fail++;
            $display("FAIL rmid_tie: got %0b%0b want 10", rdy0_2, rdy1_2); end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int l1, l2, l4;
        logic [N-1:0] exp_s, s1, s2, s4;
        pulse_reset();
        rr = 1'b1; v0 = 1'b1; a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
        exp_s = ref_add(a0, b0, c0);
        #1;
        n_checks++; if (!(rdy0_1 && rdy0_2 && rdy0_4)) begin n_fail++;
            $display("FAIL lat_accept: got %0b%0b%0b want 111", rdy0_1, rdy0_2, rdy0_4); end
        tick();
        v0 = 1'b0;
        l1 = -1; l2 = -1; l4 = -1; s1 = '0; s2 = '0; s4 = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (rv_1 && l1 < 0) begin l1 = e; s1 = rsum_1; end
            if (rv_2 && l2 < 0) begin l2 = e; s2 = rsum_2; end
            if (rv_4 && l4 < 0) begin l4 = e; s4 = rsum_4; end
        end
        n_checks++; if (l1 != 1) begin n_fail++; $display("FAIL lat1_edges: got %0d want 1", l1); end
        n_checks++; if (l2 != 2) begin n_fail++; $display("FAIL lat2_edges: got %0d want 2", l2); end
        n_checks++; if (l4 != 4) begin n_fail++; $display("FAIL lat4_edges: got %0d want 4", l4); end
        n_checks++; if (s1 !== exp_s || s2 !== exp_s || s4 !== exp_s) begin n_fail++;
            $display("FAIL lat_sums: got %0h %0h %0h want %0h", s1, s2, s4, exp_s); end
    endtask

    // Transaction model: idle/busy, edges left until the result, and the pending result.
    task automatic test_random();
        bit           m_busy, m_done, m_last, m_id, m_seen, g, acc;
        int           m_left;
        logic [N-1:0] m_sum, m_a;
        pulse_reset();
        m_busy = 1'b0; m_done = 1'b0; m_last = 1'b1; m_id = 1'b0; m_seen = 1'b0;
        m_left = 0; m_sum = '0; m_a = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v0 = ($urandom_range(0, 99) < 50); v1 = ($urandom_range(0, 99) < 50);
            a0 = $urandom; b0 = $urandom; c0 = 1'($urandom);
            a1 = $urandom; b1 = $urandom; c1 = 1'($urandom);
            rr = ($urandom_range(0, 99) < 70);
            #1;
            acc = !m_busy && (v0 || v1);
            g   = (v0 && v1) ? !m_last : v1;
            n_checks++; if (rdy0_2 !== (acc && !g)) begin n_fail++;
                $display("FAIL rnd_ready0 c%0d: got %0b want %0b", cyc, rdy0_2, acc && !g); end
            n_checks++; if (rdy1_2 !== (acc && g)) begin n_fail++;
                $display("FAIL rnd_ready1 c%0d: got %0b want %0b", cyc, rdy1_2, acc && g); end
            n_checks++; if (rv_2 !== m_done) begin n_fail++;
                $display("FAIL rnd_valid c%0d: got %0b want %0b", cyc, rv_2, m_done); end
            if (m_done) begin
                n_checks++; if (rsum_2 !== m_sum || rid_2 !== m_id) begin n_fail++;
                    $display("FAIL rnd_resp c%0d: got %0h/%0b want %0h/%0b", cyc, rsum_2, rid_2, m_sum, m_id); end
            end
            if (m_seen) begin
                n_checks++; if (adda_2 !== m_a) begin n_fail++;
                    $display("FAIL rnd_add_a c%0d: got %0h want %0h", cyc, adda_2, m_a); end
            end
            @(posedge clk);
            if (!m_busy) begin
                if (acc) begin
                    m_busy = 1'b1; m_left = LAT_M; m_id = g; m_last = g; m_seen = 1'b1;
                    m_a   = g ? a1 : a0;
                    m_sum = g ? ref_add(a1, b1, c1) : ref_add(a0, b0, c0);
                end
            end else if (!m_done) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (rr) begin
                m_busy = 1'b0; m_done = 1'b0;
            end
            #1;
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
        a0 = '0; b0 = '0; c0 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
